// File: rtl/pkg_rv.sv
// Shared definitions for the instruction fetch slice.
// Contents:
//   INSTR_W      - instruction/address width (32)
//   NOP          - canonical no-op word (addi x0,x0,0)
//   estado_t     - fetch sequencer states
//   alinhado()   - word-alignment test for a byte address
package pkg_rv;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BUSCA = 2'd0,
        CHEIA = 2'd1,
        ERRO  = 2'd2
    } estado_t;

    function automatic logic alinhado(input logic [INSTR_W-1:0] endr);
        return (endr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fila_busca.sv
// Prefetch FIFO holding {pc, instr} pairs between fetch and decode.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   push, pc_in, instr_in - write an entry at the tail
//   pop                   - drop the head entry
//   flush                 - empty the FIFO; wins over push and pop
//   cheia, vazia, count   - occupancy status
//   head_pc, head_instr   - head entry (0 / NOP when empty)
module fila_busca
    import pkg_rv::*;
#(
    parameter int FILA_PROF = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [INSTR_W-1:0]           pc_in,
    input  logic [INSTR_W-1:0]           instr_in,
    output logic                         cheia,
    output logic                         vazia,
    output logic [$clog2(FILA_PROF):0]   count,
    output logic [INSTR_W-1:0]           head_pc,
    output logic [INSTR_W-1:0]           head_instr
);

    localparam int PW = $clog2(FILA_PROF);
    localparam int CW = PW + 1;

    logic [INSTR_W-1:0] pc_mem_q    [FILA_PROF];
    logic [INSTR_W-1:0] instr_mem_q [FILA_PROF];

    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem_q[wr_q]    <= pc_in;
            instr_mem_q[wr_q] <= instr_in;
        end
    end

    assign count      = count_q;
    assign vazia      = (count_q == '0);
    assign cheia      = (count_q == CW'(FILA_PROF));
    assign head_pc    = vazia ? '0  : pc_mem_q[rd_q];
    assign head_instr = vazia ? NOP : instr_mem_q[rd_q];

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch sequencer: owns the PC, reads the word-addressed
// instruction memory combinationally, buffers fetched words in a
// prefetch FIFO and hands them to decode with a valid/ready handshake.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   endereco / instrucao       - memory address (current PC) / returned word
//   desvio_valido/desvio_alvo  - redirect request and target
//   instr_valida, instr_saida,
//   pc_saida / pronto          - head of FIFO toward decode / decode accept
//   erro                       - fetch halted on an illegal PC
module unidade_busca
    import pkg_rv::*;
#(
    parameter logic [31:0] PC_RESET     = 32'h0000_0000,
    parameter int          MEM_PALAVRAS = 64,
    parameter int          FILA_PROF    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [INSTR_W-1:0] endereco,
    input  logic [INSTR_W-1:0] instrucao,
    input  logic               desvio_valido,
    input  logic [INSTR_W-1:0] desvio_alvo,
    output logic               instr_valida,
    output logic [INSTR_W-1:0] instr_saida,
    output logic [INSTR_W-1:0] pc_saida,
    input  logic               pronto,
    output logic               erro
);

    localparam int         CW     = $clog2(FILA_PROF) + 1;
    // One bit wider than the PC so the bound itself never overflows.
    localparam logic [32:0] LIMITE = 33'(MEM_PALAVRAS) * 33'd4;

    estado_t            estado_q, estado_d;
    logic [INSTR_W-1:0] pc_q, pc_d;

    logic          push, pop, flush;
    logic          cheia, vazia;
    logic [CW-1:0] count;
    logic          pc_legal;
    logic          pode_push;

    fila_busca #(
        .FILA_PROF (FILA_PROF)
    ) u_fila (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .pc_in      (pc_q),
        .instr_in   (instrucao),
        .cheia      (cheia),
        .vazia      (vazia),
        .count      (count),
        .head_pc    (pc_saida),
        .head_instr (instr_saida)
    );

    assign instr_valida = !vazia;
    assign pop          = instr_valida && pronto;
    assign endereco     = pc_q;
    assign erro         = (estado_q == ERRO);

    assign pc_legal  = alinhado(pc_q) && ({1'b0, pc_q} < LIMITE);
    // A full FIFO can still take a word if the head leaves this cycle.
    assign pode_push = (count < CW'(FILA_PROF)) || pop;

    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        push     = 1'b0;
        flush    = 1'b0;
        if (desvio_valido) begin
            flush    = 1'b1;
            pc_d     = desvio_alvo;
            estado_d = alinhado(desvio_alvo) ? BUSCA : ERRO;
        end else begin
            case (estado_q)
                BUSCA: begin
                    if (!pc_legal) begin
                        estado_d = ERRO;
                    end else if (pode_push) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else if (cheia) begin
                        estado_d = CHEIA;
                    end
                end
                CHEIA: begin
                    if (pop) estado_d = BUSCA;
                end
                ERRO: begin
                    estado_d = ERRO;
                end
                default: begin
                    estado_d = ERRO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= BUSCA;
            pc_q     <= PC_RESET;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
        end
    end

endmodule
